accel_vec_engine: RTL and testbench

- Parametrised successor to the single-op configuration-only accelerator: a memory-to-memory vector engine.
- Configured over a peripheral (XBAR_PERIPH-style) slave port.
- Computes RES[i] = op(A[i], B[i]) for i = 0..LEN-1 over 32-bit words, fetching and storing through one TCDM master port.
- Sits in the cluster as a peripheral slave and a TCDM master; raises a one-cycle done pulse for the event unit.

---
 rtl/accel_vec_pkg.sv | 38 +++
 rtl/accel_vec_engine_alu.sv | 33 +++
 rtl/accel_vec_engine.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_accel_vec_engine.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_vec_pkg.sv
// accel_vec_engine shared definitions:
// register map, operation modes, FSM states and STATUS bit positions.
package accel_vec_pkg;

    localparam int REG_OPA    = 'h00;
    localparam int REG_OPB    = 'h04;
    localparam int REG_RES    = 'h08;
    localparam int REG_LEN    = 'h0C;
    localparam int REG_MODE   = 'h10;
    localparam int REG_CTRL   = 'h14;
    localparam int REG_STATUS = 'h18;
    localparam int REG_COUNT  = 'h1C;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ABORTED = 2;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_MUL = 2'd2,
        MODE_MAX = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_WT_A = 3'd2,
        S_RD_B = 3'd3,
        S_WT_B = 3'd4,
        S_WR   = 3'd5,
        S_WT_W = 3'd6
    } state_e;

endpackage

// File: rtl/accel_vec_engine_alu.sv
// accel_vec_engine element operator:
// purely combinational op(A, B) selected by the programmed mode.
module accel_vec_alu
    import accel_vec_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  mode_e                 mode_i,
    output logic [DATA_WIDTH-1:0] res_o
);

    logic [DATA_WIDTH-1:0] prod;
    logic                  a_gt_b;

    // Product kept at operand width: only the low word is ever stored.
    assign prod   = a_i * b_i;
    assign a_gt_b = $signed(a_i) > $signed(b_i);

    // Operation select.
    always_comb begin
        res_o = a_i + b_i;
        unique case (mode_i)
            MODE_ADD: res_o = a_i + b_i;
            MODE_SUB: res_o = a_i - b_i;
            MODE_MUL: res_o = prod;
            MODE_MAX: res_o = a_gt_b ? a_i : b_i;
            default:  res_o = a_i + b_i;
        endcase
    end

endmodule

// File: rtl/accel_vec_engine.sv
// accel_vec_engine: memory-to-memory vector engine, RES[i] = op(A[i], B[i]).
// Peripheral-slave register file plus a single-outstanding TCDM master FSM.
module accel_vec_engine
    import accel_vec_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SPACE  = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    test_mode_i,

    input  logic                    cfg_req_i,
    input  logic [ADDR_WIDTH-1:0]   cfg_add_i,
    input  logic                    cfg_wen_i,
    input  logic [DATA_WIDTH-1:0]   cfg_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cfg_be_i,
    input  logic [ID_WIDTH-1:0]     cfg_id_i,
    output logic                    cfg_gnt_o,
    output logic                    cfg_r_valid_o,
    output logic [DATA_WIDTH-1:0]   cfg_r_rdata_o,
    output logic                    cfg_r_opc_o,
    output logic [ID_WIDTH-1:0]     cfg_r_id_o,

    output logic                    tcdm_req_o,
    output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
    output logic                    tcdm_wen_o,
    output logic [DATA_WIDTH-1:0]   tcdm_wdata_o,
    output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
    input  logic                    tcdm_gnt_i,
    input  logic                    tcdm_r_valid_i,
    input  logic [DATA_WIDTH-1:0]   tcdm_r_rdata_i,

    output logic                    done_o
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int STRIDE_SH = $clog2(BE_WIDTH);

    localparam logic [MEM_SPACE-1:0] OFF_OPA    = MEM_SPACE'(REG_OPA);
    localparam logic [MEM_SPACE-1:0] OFF_OPB    = MEM_SPACE'(REG_OPB);
    localparam logic [MEM_SPACE-1:0] OFF_RES    = MEM_SPACE'(REG_RES);
    localparam logic [MEM_SPACE-1:0] OFF_LEN    = MEM_SPACE'(REG_LEN);
    localparam logic [MEM_SPACE-1:0] OFF_MODE   = MEM_SPACE'(REG_MODE);
    localparam logic [MEM_SPACE-1:0] OFF_CTRL   = MEM_SPACE'(REG_CTRL);
    localparam logic [MEM_SPACE-1:0] OFF_STATUS = MEM_SPACE'(REG_STATUS);
    localparam logic [MEM_SPACE-1:0] OFF_COUNT  = MEM_SPACE'(REG_COUNT);

    // Configuration registers.
    logic [ADDR_WIDTH-1:0] opa_q, opb_q, res_q;
    logic [LEN_WIDTH-1:0]  len_q;
    mode_e                 mode_q;

    // Engine state.
    state_e                state_q;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [LEN_WIDTH-1:0]  count_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic                  done_q, aborted_q, abort_q, done_o_q;

    // TCDM request registers.
    logic                  req_q, wen_q;
    logic [ADDR_WIDTH-1:0] add_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_WIDTH-1:0]   be_q;

    // Peripheral response registers.
    logic                  r_valid_q;
    logic [DATA_WIDTH-1:0] r_rdata_q;
    logic [ID_WIDTH-1:0]   r_id_q;

    logic [MEM_SPACE-1:0]  off;
    logic                  cfg_wr, cfg_rd;
    logic                  start_wr, abort_wr;
    logic                  busy, abort_hit, last_elem;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  unused_bits;

    assign unused_bits = ^{test_mode_i, cfg_be_i,
                           cfg_add_i[ADDR_WIDTH-1:MEM_SPACE]};

    assign off       = cfg_add_i[MEM_SPACE-1:0];
    assign cfg_wr    = cfg_req_i && !cfg_wen_i;
    assign cfg_rd    = cfg_req_i && cfg_wen_i;
    assign start_wr  = cfg_wr && (off == OFF_CTRL)
                       && cfg_wdata_i[CTRL_START];
    assign abort_wr  = cfg_wr && (off == OFF_CTRL)
                       && cfg_wdata_i[CTRL_ABORT];
    assign busy      = (state_q != S_IDLE);
    assign abort_hit = abort_q || abort_wr;
    assign idx_d     = idx_q + LEN_WIDTH'(1);
    assign last_elem = (idx_d == len_q);

    // Byte address of element idx; wraps modulo the address space.
    function automatic logic [ADDR_WIDTH-1:0] elem_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [LEN_WIDTH-1:0]  idx
    );
        return base + (ADDR_WIDTH'(idx) << STRIDE_SH);
    endfunction

    // B is consumed straight off the response bus into the store data.
    accel_vec_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) i_alu (
        .a_i    (a_q),
        .b_i    (tcdm_r_rdata_i),
        .mode_i (mode_q),
        .res_o  (alu_res)
    );

    // Read mux; unmapped offsets answer all ones.
    always_comb begin
        rd_val = '1;
        case (off)
            OFF_OPA:    rd_val = DATA_WIDTH'(opa_q);
            OFF_OPB:    rd_val = DATA_WIDTH'(opb_q);
            OFF_RES:    rd_val = DATA_WIDTH'(res_q);
            OFF_LEN:    rd_val = DATA_WIDTH'(len_q);
            OFF_MODE:   rd_val = {{(DATA_WIDTH-2){1'b0}}, mode_q};
            OFF_CTRL:   rd_val = '0;
            OFF_STATUS: rd_val = {{(DATA_WIDTH-3){1'b0}},
                                  aborted_q, done_q, busy};
            OFF_COUNT:  rd_val = DATA_WIDTH'(count_q);
            default:    rd_val = '1;
        endcase
    end

    // Peripheral response, one cycle after every granted request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= 1'b0;
            r_rdata_q <= '0;
            r_id_q    <= '0;
        end else begin
            r_valid_q <= cfg_req_i;
            if (cfg_req_i) begin
                r_id_q    <= cfg_id_i;
                r_rdata_q <= cfg_rd ? rd_val : '0;
            end
        end
    end

    // Register file writes and the fetch/compute/store sequencer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            len_q     <= '0;
            mode_q    <= MODE_ADD;
            state_q   <= S_IDLE;
            idx_q     <= '0;
            count_q   <= '0;
            a_q       <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            abort_q   <= 1'b0;
            done_o_q  <= 1'b0;
            req_q     <= 1'b0;
            wen_q     <= 1'b0;
            add_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else begin
            done_o_q <= 1'b0;

            if (abort_wr && busy) begin
                abort_q <= 1'b1;
            end

            if (cfg_wr && !busy) begin
                case (off)
                    OFF_OPA:  opa_q  <= ADDR_WIDTH'(cfg_wdata_i);
                    OFF_OPB:  opb_q  <= ADDR_WIDTH'(cfg_wdata_i);
                    OFF_RES:  res_q  <= ADDR_WIDTH'(cfg_wdata_i);
                    OFF_LEN:  len_q  <= cfg_wdata_i[LEN_WIDTH-1:0];
                    OFF_MODE: mode_q <= mode_e'(cfg_wdata_i[1:0]);
                    default:  ;
                endcase
            end

            unique case (state_q)
                S_IDLE: begin
                    if (start_wr) begin
                        done_q    <= 1'b0;
                        aborted_q <= 1'b0;
                        count_q   <= '0;
                        idx_q     <= '0;
                        abort_q   <= 1'b0;
                        if (len_q == '0) begin
                            done_q   <= 1'b1;
                            done_o_q <= 1'b1;
                        end else begin
                            state_q <= S_RD_A;
                            req_q   <= 1'b1;
                            wen_q   <= 1'b1;
                            be_q    <= '1;
                            add_q   <= opa_q;
                        end
                    end
                end
                S_RD_A: begin
                    if (tcdm_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= S_WT_A;
                    end
                end
                S_WT_A: begin
                    if (tcdm_r_valid_i) begin
                        a_q <= tcdm_r_rdata_i;
                        if (abort_hit) begin
                            state_q   <= S_IDLE;
                            aborted_q <= 1'b1;
                            done_q    <= 1'b0;
                            abort_q   <= 1'b0;
                        end else begin
                            state_q <= S_RD_B;
                            req_q   <= 1'b1;
                            wen_q   <= 1'b1;
                            add_q   <= elem_addr(opb_q, idx_q);
                        end
                    end
                end
                S_RD_B: begin
                    if (tcdm_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= S_WT_B;
                    end
                end
                S_WT_B: begin
                    if (tcdm_r_valid_i) begin
                        if (abort_hit) begin
                            state_q   <= S_IDLE;
                            aborted_q <= 1'b1;
                            done_q    <= 1'b0;
                            abort_q   <= 1'b0;
                        end else begin
                            state_q <= S_WR;
                            req_q   <= 1'b1;
                            wen_q   <= 1'b0;
                            add_q   <= elem_addr(res_q, idx_q);
                            wdata_q <= alu_res;
                        end
                    end
                end
                S_WR: begin
                    if (tcdm_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= S_WT_W;
                    end
                end
                S_WT_W: begin
                    if (tcdm_r_valid_i) begin
                        count_q <= count_q + LEN_WIDTH'(1);
                        idx_q   <= idx_d;
                        if (abort_hit) begin
                            state_q   <= S_IDLE;
                            aborted_q <= 1'b1;
                            done_q    <= 1'b0;
                            abort_q   <= 1'b0;
                        end else if (last_elem) begin
                            state_q  <= S_IDLE;
                            done_q   <= 1'b1;
                            done_o_q <= 1'b1;
                        end else begin
                            state_q <= S_RD_A;
                            req_q   <= 1'b1;
                            wen_q   <= 1'b1;
                            add_q   <= elem_addr(opa_q, idx_d);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_gnt_o     = cfg_req_i;
    assign cfg_r_valid_o = r_valid_q;
    assign cfg_r_rdata_o = r_rdata_q;
    assign cfg_r_opc_o   = 1'b0;
    assign cfg_r_id_o    = r_id_q;

    assign tcdm_req_o    = req_q;
    assign tcdm_add_o    = add_q;
    assign tcdm_wen_o    = wen_q;
    assign tcdm_wdata_o  = wdata_q;
    assign tcdm_be_o     = be_q;

    assign done_o        = done_o_q;

endmodule

// File: tb/tb_accel_vec_engine.sv
// Bench for accel_vec_engine: TCDM memory model with optional backpressure,
// store scoreboard, cfg register checks, abort and reset scenarios.
module tb_accel_vec_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_req = 1'b0;
    logic [31:0] cfg_add = '0;
    logic        cfg_wen = 1'b1;
    logic [31:0] cfg_wdata = '0;
    logic [3:0]  cfg_id = '0;
    logic        cfg_gnt, cfg_r_valid, cfg_r_opc;
    logic [31:0] cfg_r_rdata;
    logic [3:0]  cfg_r_id;
    logic        tcdm_req_o, tcdm_wen_o;
    logic [31:0] tcdm_add_o, tcdm_wdata_o;
    logic [3:0]  tcdm_be_o;
    logic        tcdm_gnt = 1'b0;
    logic        tcdm_r_valid = 1'b0;
    logic [31:0] tcdm_r_rdata = '0;
    logic        done_o;

    always #5 clk = ~clk;

    accel_vec_engine dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .test_mode_i    (1'b0),
        .cfg_req_i      (cfg_req),
        .cfg_add_i      (cfg_add),
        .cfg_wen_i      (cfg_wen),
        .cfg_wdata_i    (cfg_wdata),
        .cfg_be_i       (4'hF),
        .cfg_id_i       (cfg_id),
        .cfg_gnt_o      (cfg_gnt),
        .cfg_r_valid_o  (cfg_r_valid),
        .cfg_r_rdata_o  (cfg_r_rdata),
        .cfg_r_opc_o    (cfg_r_opc),
        .cfg_r_id_o     (cfg_r_id),
        .tcdm_req_o     (tcdm_req_o),
        .tcdm_add_o     (tcdm_add_o),
        .tcdm_wen_o     (tcdm_wen_o),
        .tcdm_wdata_o   (tcdm_wdata_o),
        .tcdm_be_o      (tcdm_be_o),
        .tcdm_gnt_i     (tcdm_gnt),
        .tcdm_r_valid_i (tcdm_r_valid),
        .tcdm_r_rdata_i (tcdm_r_rdata),
        .done_o         (done_o)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_chk = 0;
    int          n_err = 0;
    int          n_req = 0;
    int          n_done = 0;
    bit          bp = 1'b0;
    bit          hold_wr = 1'b0;
    logic [3:0]  id_ctr = 4'h3;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_op(input int mode,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        case (mode)
            0: return a + b;
            1: return a - b;
            2: return p[31:0];
            default: return ($signed(a) > $signed(b)) ? a : b;
        endcase
    endfunction

    always @(negedge clk) if (done_o) n_done++;

    // TCDM slave: one transaction at a time, optional random gnt/r_valid delay.
    initial begin
        logic [31:0] sa, sd, rd;
        logic        sw;
        int          dly, lat;
        forever begin
            @(negedge clk);
            if (rst_n && tcdm_req_o) begin
                sa  = tcdm_add_o;
                sw  = tcdm_wen_o;
                sd  = tcdm_wdata_o;
                dly = bp ? $urandom_range(0, 5) : 0;
                while (rst_n && (dly > 0 || (hold_wr && !sw))) begin
                    @(negedge clk);
                    if (rst_n) begin
                        check("req_held", 32'(tcdm_req_o), 32'h1);
                        check("add_stable", tcdm_add_o, sa);
                        check("wen_stable", 32'(tcdm_wen_o), 32'(sw));
                        check("wdata_stable", tcdm_wdata_o, sd);
                    end
                    if (dly > 0) dly--;
                end
                if (rst_n) begin
                    tcdm_gnt = 1'b1;
                    n_req++;
                    rd = 32'h0;
                    if (sw) begin
                        rd = mrd(sa);
                    end else begin
                        mem[sa] = sd;
                        check("be_full", 32'(tcdm_be_o), 32'hF);
                        check("sb_pending", 32'(exp_q.size() > 0), 32'h1);
                        if (exp_q.size() > 0) begin
                            wr_t e;
                            e = exp_q.pop_front();
                            check("wr_addr", sa, e.a);
                            check("wr_data", sd, e.d);
                        end
                    end
                    @(negedge clk);
                    tcdm_gnt = 1'b0;
                    lat = bp ? $urandom_range(1, 3) : 1;
                    for (int k = 1; k < lat; k++) begin
                        @(negedge clk);
                        check("one_outstanding", 32'(tcdm_req_o), 32'h0);
                    end
                    tcdm_r_valid = 1'b1;
                    tcdm_r_rdata = rd;
                    @(negedge clk);
                    tcdm_r_valid = 1'b0;
                end
            end
        end
    end

    task automatic cfg_rd(input int a, output logic [31:0] d);
        @(negedge clk);
        cfg_req = 1'b1;
        cfg_wen = 1'b1;
        cfg_add = 32'(a);
        cfg_id  = id_ctr;
        @(negedge clk);
        cfg_req = 1'b0;
        check("rd_rvalid", 32'(cfg_r_valid), 32'h1);
        check("rd_rid", 32'(cfg_r_id), 32'(id_ctr));
        d = cfg_r_rdata;
        id_ctr++;
    endtask

    task automatic cfg_wr(input int a, input logic [31:0] d);
        @(negedge clk);
        cfg_req   = 1'b1;
        cfg_wen   = 1'b0;
        cfg_add   = 32'(a);
        cfg_wdata = d;
        cfg_id    = id_ctr;
        @(negedge clk);
        cfg_req = 1'b0;
        check("wr_rvalid", 32'(cfg_r_valid), 32'h1);
        check("wr_rid", 32'(cfg_r_id), 32'(id_ctr));
        id_ctr++;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (n_done > d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic setup(input logic [31:0] opa, input logic [31:0] opb,
                         input logic [31:0] res, input int len,
                         input int mode);
        cfg_wr('h00, opa);
        cfg_wr('h04, opb);
        cfg_wr('h08, res);
        cfg_wr('h0C, 32'(len));
        cfg_wr('h10, 32'(mode));
        for (int i = 0; i < len; i++) begin
            wr_t e;
            e.a = res + 32'(i * 4);
            e.d = ref_op(mode, mrd(opa + 32'(i * 4)), mrd(opb + 32'(i * 4)));
            exp_q.push_back(e);
        end
    endtask

    task automatic do_run(input logic [31:0] opa, input logic [31:0] opb,
                          input logic [31:0] res, input int len,
                          input int mode);
        logic [31:0] v;
        int          d0;
        bit          ok;
        setup(opa, opb, res, len, mode);
        d0 = n_done;
        cfg_wr('h14, 32'h1);
        wait_done(d0, 20000, ok);
        check("done_seen", 32'(ok), 32'h1);
        repeat (4) @(negedge clk);
        check("done_pulses", 32'(n_done - d0), 32'h1);
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        cfg_rd('h1C, v);
        check("count", v, 32'(len));
        cfg_rd('h18, v);
        check("status_done", v, 32'h2);
    endtask

    task automatic read_all_zero(input string tag);
        logic [31:0] v;
        for (int r = 0; r < 8; r++) begin
            cfg_rd(r * 4, v);
            check(tag, v, 32'h0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int          d0, r0, cnt, popped;
        bit          ok;

        for (int i = 0; i < 100; i++) begin
            mem[32'h1000 + 32'(i * 4)] = 32'(i + 1);
            mem[32'h2000 + 32'(i * 4)] = 32'(10 * (i + 1));
        end
        mem[32'h5000] = 32'hFFFF_FFFE;
        mem[32'h6000] = 32'h3;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and response timing.
        read_all_zero("reset_reg");
        cfg_rd('h40, v);
        check("unmapped_rd", v, 32'hFFFF_FFFF);
        @(negedge clk);
        check("rvalid_one_cycle", 32'(cfg_r_valid), 32'h0);
        check("r_opc", 32'(cfg_r_opc), 32'h0);

        // Vector add.
        do_run(32'h1000, 32'h2000, 32'h3000, 3, 0);
        check("add_res0", mrd(32'h3000), 32'd11);
        check("add_res1", mrd(32'h3004), 32'd22);
        check("add_res2", mrd(32'h3008), 32'd33);

        // Modes on A = -2, B = 3.
        do_run(32'h5000, 32'h6000, 32'h7004, 1, 1);
        check("mode_sub", mrd(32'h7004), 32'hFFFF_FFFB);
        do_run(32'h5000, 32'h6000, 32'h7008, 1, 2);
        check("mode_mul", mrd(32'h7008), 32'hFFFF_FFFA);
        do_run(32'h5000, 32'h6000, 32'h700C, 1, 3);
        check("mode_max", mrd(32'h700C), 32'h3);

        // Backpressure on every mode with random operands.
        for (int i = 0; i < 8; i++) begin
            mem[32'h1000 + 32'(i * 4)] = $urandom;
            mem[32'h2000 + 32'(i * 4)] = $urandom;
        end
        bp = 1'b1;
        for (int m = 0; m < 4; m++) begin
            do_run(32'h1000, 32'h2000, 32'h9000 + 32'(m * 'h100), 8, m);
        end
        bp = 1'b0;

        // Busy protection and abort.
        setup(32'h1000, 32'h2000, 32'h8000, 100, 0);
        d0 = n_done;
        cfg_wr('h14, 32'h1);
        cfg_wr('h00, 32'h0);
        v = 0;
        for (int t = 0; t < 300 && v < 5; t++) cfg_rd('h1C, v);
        cfg_wr('h14, 32'h2);
        v = 32'h1;
        for (int t = 0; t < 100 && v[0]; t++) cfg_rd('h18, v);
        check("abort_status", v, 32'h4);
        cfg_rd('h1C, v);
        cnt = int'(v);
        check("abort_count_5_6", 32'(cnt == 5 || cnt == 6), 32'h1);
        popped = 100 - exp_q.size();
        check("abort_stores", 32'(popped), 32'(cnt));
        r0 = n_req;
        repeat (30) @(negedge clk);
        check("abort_no_req", 32'(n_req - r0), 32'h0);
        check("abort_no_done", 32'(n_done - d0), 32'h0);
        cfg_rd('h00, v);
        check("busy_wr_dropped", v, 32'h1000);
        exp_q.delete();

        // LEN = 0: immediate done, no traffic.
        cfg_wr('h0C, 32'h0);
        r0 = n_req;
        @(negedge clk);
        cfg_req   = 1'b1;
        cfg_wen   = 1'b0;
        cfg_add   = 32'h14;
        cfg_wdata = 32'h1;
        @(negedge clk);
        cfg_req = 1'b0;
        check("len0_done_o", 32'(done_o), 32'h1);
        @(negedge clk);
        check("len0_done_o_drop", 32'(done_o), 32'h0);
        repeat (5) @(negedge clk);
        check("len0_no_req", 32'(n_req - r0), 32'h0);
        cfg_rd('h18, v);
        check("len0_status", v, 32'h2);

        // Store address wraps past the top of memory.
        do_run(32'h1000, 32'h2000, 32'hFFFF_FFFC, 2, 0);
        check("wrap_res0", mrd(32'hFFFF_FFFC),
              mrd(32'h1000) + mrd(32'h2000));
        check("wrap_res1", mrd(32'h0), mrd(32'h1004) + mrd(32'h2004));

        // Reset while a store is pending.
        hold_wr = 1'b1;
        setup(32'h1000, 32'h2000, 32'hA000, 1, 0);
        cfg_wr('h14, 32'h1);
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = tcdm_req_o && !tcdm_wen_o;
        end
        check("reached_wr", 32'(ok), 32'h1);
        #2 rst_n = 1'b0;
        #1 check("rst_req_low", 32'(tcdm_req_o), 32'h0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        hold_wr = 1'b0;
        rst_n = 1'b1;
        read_all_zero("post_rst_reg");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
